// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: holds loads/stores until the data cache acks,
// stalls upstream while waiting, tracks the LL/SC link and registers MEM/WB.
module mem_access_stage #(
  parameter bit LINK_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        em_valid,
  input  logic [5:0]  em_opcode,
  input  logic [31:0] em_alu_out,
  input  logic [31:0] em_rdat2,
  input  logic [31:0] em_npc,
  input  logic [31:0] em_extout,
  input  logic [4:0]  em_rt,
  input  logic [4:0]  em_rd,
  input  logic        em_DRen,
  input  logic        em_DWen,
  input  logic        em_RegW,
  input  logic        em_halt,
  input  logic [1:0]  em_Mem,
  input  logic [1:0]  em_RegDest,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        datomic,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_RegW,
  output logic        wb_halt,
  output logic [4:0]  wb_wsel,
  output logic [31:0] wb_wdat,
  output logic [1:0]  dbg_state
);

  localparam logic [5:0] OP_LL = 6'h30;
  localparam logic [5:0] OP_SC = 6'h38;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        link_valid_q, link_valid_d;
  logic [31:0] link_addr_q, link_addr_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic        atomic_q, atomic_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_regw_q, wb_regw_d;
  logic        wb_halt_q, wb_halt_d;
  logic [4:0]  wb_wsel_q, wb_wsel_d;
  logic [31:0] wb_wdat_q, wb_wdat_d;

  logic        stall;
  logic        is_ll, is_sc, is_mem, link_hit, sc_fail;
  logic [4:0]  wsel_mux;
  logic [31:0] wdat_mux;

  always_comb begin
    is_ll    = (em_opcode == OP_LL);
    is_sc    = (em_opcode == OP_SC);
    is_mem   = em_DRen | em_DWen;
    link_hit = link_valid_q && (link_addr_q == em_alu_out);
    sc_fail  = (LINK_EN == 1'b1) && is_sc && !link_hit;

    case (em_RegDest)
      2'd1:    wsel_mux = em_rd;
      2'd2:    wsel_mux = 5'd31;
      default: wsel_mux = em_rt;
    endcase

    case (em_Mem)
      2'd0:    wdat_mux = em_alu_out;
      2'd1:    wdat_mux = dmemload;
      2'd2:    wdat_mux = em_npc;
      default: wdat_mux = em_extout;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    ren_d        = ren_q;
    wen_d        = wen_q;
    atomic_d     = atomic_q;
    addr_d       = addr_q;
    store_d      = store_q;
    wb_valid_d   = wb_valid_q;
    wb_regw_d    = wb_regw_q;
    wb_halt_d    = wb_halt_q;
    wb_wsel_d    = wb_wsel_q;
    wb_wdat_d    = wb_wdat_q;
    stall        = 1'b0;

    // Remote invalidation; an LL completing this same cycle overrides below.
    if (snoop_inv && link_valid_q && (snoop_addr == link_addr_q)) begin
      link_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!em_valid) begin
          wb_valid_d = 1'b0;
          wb_regw_d  = 1'b0;
          wb_halt_d  = 1'b0;
        end else if (em_halt) begin
          state_d    = HALTED;
          wb_valid_d = 1'b1;
          wb_regw_d  = em_RegW;
          wb_halt_d  = 1'b1;
          wb_wsel_d  = wsel_mux;
          wb_wdat_d  = wdat_mux;
        end else if (is_mem && !sc_fail) begin
          stall    = 1'b1;
          state_d  = ACCESS;
          ren_d    = em_DRen;
          wen_d    = em_DWen;
          atomic_d = is_ll | is_sc;
          addr_d   = em_alu_out;
          store_d  = em_rdat2;
        end else begin
          wb_valid_d = 1'b1;
          wb_regw_d  = em_RegW;
          wb_halt_d  = 1'b0;
          wb_wsel_d  = sc_fail ? em_rt : wsel_mux;
          wb_wdat_d  = sc_fail ? 32'd0 : wdat_mux;
        end
      end

      ACCESS: begin
        stall = ~dhit;
        if (dhit) begin
          state_d    = IDLE;
          ren_d      = 1'b0;
          wen_d      = 1'b0;
          atomic_d   = 1'b0;
          addr_d     = 32'd0;
          store_d    = 32'd0;
          wb_valid_d = 1'b1;
          wb_regw_d  = em_RegW & em_valid;
          wb_halt_d  = 1'b0;
          wb_wsel_d  = wsel_mux;
          wb_wdat_d  = is_sc ? 32'd1 : wdat_mux;
          if ((em_DWen && link_hit) || is_sc) begin
            link_valid_d = 1'b0;
          end
          if (is_ll && (LINK_EN == 1'b1)) begin
            link_valid_d = 1'b1;
            link_addr_d  = em_alu_out;
          end
        end
      end

      HALTED: begin
        wb_valid_d = 1'b0;
        wb_regw_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      link_valid_q <= 1'b0;
      link_addr_q  <= 32'd0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      atomic_q     <= 1'b0;
      addr_q       <= 32'd0;
      store_q      <= 32'd0;
      wb_valid_q   <= 1'b0;
      wb_regw_q    <= 1'b0;
      wb_halt_q    <= 1'b0;
      wb_wsel_q    <= 5'd0;
      wb_wdat_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      atomic_q     <= atomic_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      wb_valid_q   <= wb_valid_d;
      wb_regw_q    <= wb_regw_d;
      wb_halt_q    <= wb_halt_d;
      wb_wsel_q    <= wb_wsel_d;
      wb_wdat_q    <= wb_wdat_d;
    end
  end

  assign dmemREN   = ren_q;
  assign dmemWEN   = wen_q;
  assign dmemaddr  = addr_q;
  assign dmemstore = store_q;
  assign datomic   = atomic_q;
  assign mem_stall = stall;
  assign wb_valid  = wb_valid_q;
  assign wb_RegW   = wb_regw_q;
  assign wb_halt   = wb_halt_q;
  assign wb_wsel   = wb_wsel_q;
  assign wb_wdat   = wb_wdat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized instruction
// streams compared against a transaction-level model of the stage and link.
module tb_mem_access_stage;

  logic        CLK, RST;
  logic        em_valid;
  logic [5:0]  em_opcode;
  logic [31:0] em_alu_out, em_rdat2, em_npc, em_extout;
  logic [4:0]  em_rt, em_rd;
  logic        em_DRen, em_DWen, em_RegW, em_halt;
  logic [1:0]  em_Mem, em_RegDest;
  logic        dhit;
  logic [31:0] dmemload;
  logic        snoop_inv;
  logic [31:0] snoop_addr;
  logic        dmemREN, dmemWEN, datomic, mem_stall;
  logic [31:0] dmemaddr, dmemstore;
  logic        wb_valid, wb_RegW, wb_halt;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;
  logic [1:0]  dbg_state;

  mem_access_stage #(.LINK_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .em_valid(em_valid), .em_opcode(em_opcode),
    .em_alu_out(em_alu_out), .em_rdat2(em_rdat2), .em_npc(em_npc),
    .em_extout(em_extout), .em_rt(em_rt), .em_rd(em_rd), .em_DRen(em_DRen),
    .em_DWen(em_DWen), .em_RegW(em_RegW), .em_halt(em_halt), .em_Mem(em_Mem),
    .em_RegDest(em_RegDest), .dhit(dhit), .dmemload(dmemload),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .datomic(datomic), .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_RegW(wb_RegW), .wb_halt(wb_halt), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [5:0]  op;
    logic        dren, dwen, regw, halt;
    logic [1:0]  mem, regdest;
    logic [4:0]  rt, rd;
    logic [31:0] alu, rdat2, npc, ext, load;
    int          waits;
  } instr_t;

  typedef struct {
    int          ren_n, wen_n, stall_n;
    logic [31:0] addr, store;
    logic        atomic, wbv, regw, halt;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    bit          timeout;
  } obs_t;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  // Model of the link register: LL sets it, matching store/SC/snoop clear it.
  bit          m_lv = 0;
  logic [31:0] m_la = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic instr_t mk_instr(input int kind, input logic [31:0] alu, input int waits);
    instr_t i;
    i.alu = alu; i.waits = waits;
    i.rt = 5'($urandom_range(1, 31)); i.rd = 5'($urandom_range(1, 31));
    i.rdat2 = $urandom; i.npc = $urandom; i.ext = $urandom; i.load = $urandom;
    i.halt = 0; i.dren = 0; i.dwen = 0; i.regw = 1; i.regdest = 2'd0; i.mem = 2'd0;
    case (kind)
      1: begin i.op = 6'h23; i.dren = 1; i.mem = 2'd1; end
      2: begin i.op = 6'h2B; i.dwen = 1; i.regw = 0; end
      3: begin i.op = 6'h30; i.dren = 1; i.mem = 2'd1; end
      4: begin i.op = 6'h38; i.dwen = 1; end
      default: begin
        i.op = 6'h00;
        i.regdest = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0: i.mem = 2'd0;
          1: i.mem = 2'd2;
          default: i.mem = 2'd3;
        endcase
      end
    endcase
    return i;
  endfunction

  function automatic obs_t predict(input instr_t i);
    obs_t e;
    bit is_mem, is_sc, fail;
    logic [31:0] src;
    is_mem = i.dren | i.dwen;
    is_sc = (i.op == 6'h38);
    fail = is_sc && !(m_lv && m_la == i.alu);
    e.ren_n = 0; e.wen_n = 0; e.stall_n = 0; e.timeout = 0;
    e.addr = i.alu; e.store = i.rdat2; e.atomic = (i.op == 6'h30) || is_sc;
    e.wbv = 1; e.regw = i.regw; e.halt = i.halt;
    if (i.regdest == 2'd1) e.wsel = i.rd;
    else if (i.regdest == 2'd2) e.wsel = 5'd31;
    else e.wsel = i.rt;
    if (i.mem == 2'd0) src = i.alu;
    else if (i.mem == 2'd1) src = i.load;
    else if (i.mem == 2'd2) src = i.npc;
    else src = i.ext;
    e.wdat = src;
    if (!i.halt && is_mem && !fail) begin
      e.ren_n = i.dren ? i.waits + 1 : 0;
      e.wen_n = i.dwen ? i.waits + 1 : 0;
      e.stall_n = i.waits + 1;
      if (is_sc) e.wdat = 32'd1;
    end else if (!i.halt && fail) begin
      e.wdat = 32'd0;
      e.wsel = i.rt;
    end
    return e;
  endfunction

  task automatic model_commit(input instr_t i);
    bit is_sc, fail;
    is_sc = (i.op == 6'h38);
    fail = is_sc && !(m_lv && m_la == i.alu);
    if (!i.halt && (i.dren | i.dwen) && !fail) begin
      if (i.dwen && m_lv && m_la == i.alu) m_lv = 0;
      if (is_sc) m_lv = 0;
      if (i.op == 6'h30) begin m_lv = 1; m_la = i.alu; end
    end
  endtask

  task automatic set_em(input instr_t i);
    em_opcode = i.op; em_alu_out = i.alu; em_rdat2 = i.rdat2; em_npc = i.npc;
    em_extout = i.ext; em_rt = i.rt; em_rd = i.rd; em_DRen = i.dren;
    em_DWen = i.dwen; em_RegW = i.regw; em_halt = i.halt; em_Mem = i.mem;
    em_RegDest = i.regdest; dmemload = i.load;
  endtask

  // Presents one instruction, acks the cache after i.waits access cycles and
  // records what the DUT did until the MEM/WB latch captured it.
  task automatic drive_instr(input instr_t i, output obs_t o);
    int acc;
    bit done;
    o.ren_n = 0; o.wen_n = 0; o.stall_n = 0; o.addr = 0; o.store = 0;
    o.atomic = 0; o.timeout = 0;
    acc = 0; done = 0;
    @(posedge CLK); #1;
    set_em(i); em_valid = 1; dhit = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) begin @(posedge CLK); #1; end
      if (dmemREN | dmemWEN) begin dhit = (acc == i.waits); acc++; end
      else dhit = 0;
      @(negedge CLK);
      if (dmemREN) o.ren_n++;
      if (dmemWEN) o.wen_n++;
      if (mem_stall) o.stall_n++;
      if (dmemREN | dmemWEN) begin
        o.addr = dmemaddr; o.store = dmemstore; o.atomic = datomic;
      end
      if (!mem_stall) begin done = 1; break; end
    end
    o.timeout = !done;
    @(posedge CLK); #1;
    o.wbv = wb_valid; o.regw = wb_RegW; o.halt = wb_halt;
    o.wsel = wb_wsel; o.wdat = wb_wdat;
    em_valid = 0; dhit = 0;
  endtask

  task automatic pulse_snoop(input logic [31:0] a);
    @(posedge CLK); #1;
    em_valid = 0; snoop_inv = 1; snoop_addr = a;
    @(posedge CLK); #1;
    snoop_inv = 0;
    if (m_lv && m_la == a) m_lv = 0;
  endtask

  task automatic test_reset;
    #12;
    tests++;
    if ({dmemREN, dmemWEN, datomic, wb_valid, wb_RegW, wb_halt} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 000000", {dmemREN, dmemWEN, datomic, wb_valid, wb_RegW, wb_halt});
    end
    tests++;
    if ({dmemaddr, dmemstore, wb_wdat, wb_wsel} !== 101'd0) begin
      fails++;
      $display("FAIL reset_data: addr %h store %h wdat %h wsel %0d want all 0", dmemaddr, dmemstore, wb_wdat, wb_wsel);
    end
    tests++;
    if (dbg_state !== 2'd0 || mem_stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: state %0d stall %b want 0 0", dbg_state, mem_stall);
    end
    @(negedge CLK); RST = 0;
    @(negedge CLK);
    tests++;
    if (wb_valid !== 1'b0 || mem_stall !== 1'b0) begin
      fails++;
      $display("FAIL idle_bubble: wb_valid %b stall %b want 0 0", wb_valid, mem_stall);
    end
  endtask

  task automatic test_add;
    instr_t i; obs_t o;
    i = mk_instr(0, 32'h1234, 0);
    i.regdest = 2'd1; i.rd = 5'd5; i.mem = 2'd0; i.regw = 1;
    drive_instr(i, o);
    tests++;
    if (o.stall_n !== 0 || o.ren_n !== 0 || o.wen_n !== 0) begin
      fails++;
      $display("FAIL add_nostall: stall %0d ren %0d wen %0d want 0 0 0", o.stall_n, o.ren_n, o.wen_n);
    end
    tests++;
    if (o.wsel !== 5'd5 || o.wdat !== 32'h1234 || o.regw !== 1'b1 || o.wbv !== 1'b1) begin
      fails++;
      $display("FAIL add_wb: wsel %0d wdat %h regw %b valid %b want 5 1234 1 1", o.wsel, o.wdat, o.regw, o.wbv);
    end
  endtask

  task automatic test_lw_wait;
    instr_t i; obs_t o;
    i = mk_instr(1, 32'h100, 3);
    i.load = 32'hDEADBEEF;
    drive_instr(i, o);
    tests++;
    if (o.timeout) begin fails++; $display("FAIL lw_timeout: no MEM/WB capture in 40 cycles"); end
    tests++;
    if (o.ren_n !== 4 || o.stall_n !== 4 || o.wen_n !== 0) begin
      fails++;
      $display("FAIL lw_cycles: ren %0d stall %0d wen %0d want 4 4 0", o.ren_n, o.stall_n, o.wen_n);
    end
    tests++;
    if (o.wdat !== 32'hDEADBEEF || o.wsel !== i.rt || o.addr !== 32'h100) begin
      fails++;
      $display("FAIL lw_data: wdat %h wsel %0d addr %h want deadbeef %0d 100", o.wdat, o.wsel, o.addr, i.rt);
    end
    model_commit(i);
  endtask

  task automatic test_ll_sc;
    instr_t i; obs_t o, e;
    i = mk_instr(3, 32'h200, $urandom_range(0, 2));
    e = predict(i); drive_instr(i, o); model_commit(i);
    tests++;
    if (o.ren_n !== e.ren_n || o.wdat !== e.wdat || o.atomic !== 1'b1) begin
      fails++;
      $display("FAIL ll_load: ren %0d wdat %h atomic %b want %0d %h 1", o.ren_n, o.wdat, o.atomic, e.ren_n, e.wdat);
    end
    i = mk_instr(4, 32'h200, $urandom_range(0, 2));
    drive_instr(i, o); model_commit(i);
    tests++;
    if (o.wen_n !== i.waits + 1 || o.wdat !== 32'd1 || o.store !== i.rdat2) begin
      fails++;
      $display("FAIL sc_success: wen %0d wdat %h store %h want %0d 1 %h", o.wen_n, o.wdat, o.store, i.waits + 1, i.rdat2);
    end
    i = mk_instr(4, 32'h200, 0);
    drive_instr(i, o); model_commit(i);
    tests++;
    if (o.wen_n !== 0 || o.stall_n !== 0 || o.wdat !== 32'd0 || o.wsel !== i.rt) begin
      fails++;
      $display("FAIL sc_second: wen %0d stall %0d wdat %h wsel %0d want 0 0 0 %0d", o.wen_n, o.stall_n, o.wdat, o.wsel, i.rt);
    end
  endtask

  task automatic test_snoop;
    instr_t i; obs_t o;
    i = mk_instr(3, 32'h200, 0); drive_instr(i, o); model_commit(i);
    pulse_snoop(32'h200);
    @(negedge CLK);
    tests++;
    if (wb_valid !== 1'b0 || wb_RegW !== 1'b0) begin
      fails++;
      $display("FAIL bubble_wb: valid %b regw %b want 0 0", wb_valid, wb_RegW);
    end
    i = mk_instr(4, 32'h200, 0); drive_instr(i, o); model_commit(i);
    tests++;
    if (o.wen_n !== 0 || o.wdat !== 32'd0) begin
      fails++;
      $display("FAIL snoop_hit_sc: wen %0d wdat %h want 0 0", o.wen_n, o.wdat);
    end
    i = mk_instr(3, 32'h200, 1); drive_instr(i, o); model_commit(i);
    pulse_snoop(32'h204);
    i = mk_instr(4, 32'h200, 1); drive_instr(i, o); model_commit(i);
    tests++;
    if (o.wen_n !== 2 || o.wdat !== 32'd1) begin
      fails++;
      $display("FAIL snoop_miss_sc: wen %0d wdat %h want 2 1", o.wen_n, o.wdat);
    end
  endtask

  task automatic test_reset_mid_access;
    instr_t i; obs_t o;
    bit seen;
    i = mk_instr(2, 32'h300, 0);
    @(posedge CLK); #1;
    set_em(i); em_valid = 1; dhit = 0; seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      if (dmemWEN) begin seen = 1; break; end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL sw_issue: dmemWEN got 0 want 1 within 10 cycles"); end
    #2 RST = 1;
    #1;
    tests++;
    if (dmemWEN !== 1'b0 || dbg_state !== 2'd0) begin
      fails++;
      $display("FAIL rst_abort: wen %b state %0d want 0 0", dmemWEN, dbg_state);
    end
    em_valid = 0;
    @(negedge CLK); RST = 0;
    m_lv = 0; m_la = 0;
    i = mk_instr(1, 32'h104, 2);
    drive_instr(i, o); model_commit(i);
    tests++;
    if (o.ren_n !== 3 || o.wdat !== i.load || o.addr !== 32'h104) begin
      fails++;
      $display("FAIL lw_after_rst: ren %0d wdat %h addr %h want 3 %h 104", o.ren_n, o.wdat, o.addr, i.load);
    end
  endtask

  task automatic test_random;
    instr_t i; obs_t o, e;
    logic [31:0] addrs[3];
    logic [31:0] want;
    addrs[0] = 32'h200; addrs[1] = 32'h204; addrs[2] = 32'h300;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) pulse_snoop(addrs[$urandom_range(0, 2)]);
      i = mk_instr($urandom_range(0, 4), addrs[$urandom_range(0, 2)], $urandom_range(0, 3));
      e = predict(i);
      exp_q.push_back(e.wdat);
      drive_instr(i, o);
      model_commit(i);
      want = exp_q.pop_front();
      tests++;
      if (o.timeout || o.ren_n !== e.ren_n || o.wen_n !== e.wen_n || o.stall_n !== e.stall_n) begin
        fails++;
        $display("FAIL rand_cycles[%0d] op %h: ren %0d wen %0d stall %0d to %b want %0d %0d %0d 0",
                 n, i.op, o.ren_n, o.wen_n, o.stall_n, o.timeout, e.ren_n, e.wen_n, e.stall_n);
      end
      tests++;
      if (o.wdat !== want || o.wsel !== e.wsel || o.regw !== e.regw || o.wbv !== 1'b1) begin
        fails++;
        $display("FAIL rand_wb[%0d] op %h: wdat %h wsel %0d regw %b valid %b want %h %0d %b 1",
                 n, i.op, o.wdat, o.wsel, o.regw, o.wbv, want, e.wsel, e.regw);
      end
      if (e.ren_n + e.wen_n > 0) begin
        tests++;
        if (o.addr !== e.addr || o.atomic !== e.atomic || (i.dwen && o.store !== e.store)) begin
          fails++;
          $display("FAIL rand_req[%0d]: addr %h atomic %b store %h want %h %b %h",
                   n, o.addr, o.atomic, o.store, e.addr, e.atomic, e.store);
        end
      end
    end
  endtask

  task automatic test_halt;
    instr_t i; obs_t o;
    int bad;
    i = mk_instr(0, 32'h55, 0);
    i.halt = 1;
    drive_instr(i, o);
    tests++;
    if (o.halt !== 1'b1 || dbg_state !== 2'd2) begin
      fails++;
      $display("FAIL halt_wb: wb_halt %b state %0d want 1 2", o.halt, dbg_state);
    end
    i = mk_instr(1, 32'h100, 0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      set_em(i); em_valid = 1; dhit = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (dmemREN || dmemWEN || mem_stall || wb_valid || !wb_halt) bad++;
    end
    em_valid = 0; dhit = 0;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL halted_quiet: %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    RST = 1; em_valid = 0; em_opcode = 0; em_alu_out = 0; em_rdat2 = 0;
    em_npc = 0; em_extout = 0; em_rt = 0; em_rd = 0; em_DRen = 0; em_DWen = 0;
    em_RegW = 0; em_halt = 0; em_Mem = 0; em_RegDest = 0; dhit = 0;
    dmemload = 0; snoop_inv = 0; snoop_addr = 0;
    test_reset;
    test_add;
    test_lw_wait;
    test_ll_sc;
    test_snoop;
    test_reset_mid_access;
    test_random;
    test_halt;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
